// File: rtl/sys_cmd_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_cmd_host_pkg
// Description : Shared command codes, command-type enum and per-type frame and
//               response lengths for the UART register/ALU command host.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_cmd_host_pkg;

    // Leading byte of each frame on the wire
    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // Parallel command type as presented on cmd_type
    typedef enum logic [1:0] {
        CT_RF_WR   = 2'd0,
        CT_RF_RD   = 2'd1,
        CT_ALU_OP  = 2'd2,
        CT_ALU_NOP = 2'd3
    } cmd_type_e;

    // Bytes sent per frame, including the command byte
    localparam logic [2:0] FRAME_LEN_RF_WR   = 3'd3;
    localparam logic [2:0] FRAME_LEN_RF_RD   = 3'd2;
    localparam logic [2:0] FRAME_LEN_ALU_OP  = 3'd4;
    localparam logic [2:0] FRAME_LEN_ALU_NOP = 3'd2;

    // Response bytes expected back per command
    localparam logic [1:0] RSP_LEN_RF_WR   = 2'd0;
    localparam logic [1:0] RSP_LEN_RF_RD   = 2'd1;
    localparam logic [1:0] RSP_LEN_ALU_OP  = 2'd2;
    localparam logic [1:0] RSP_LEN_ALU_NOP = 2'd2;

    function automatic logic [7:0] cmd_code(input cmd_type_e t);
        logic [7:0] code;
        case (t)
            CT_RF_WR:  code = CMD_RF_WR;
            CT_RF_RD:  code = CMD_RF_RD;
            CT_ALU_OP: code = CMD_ALU_OP;
            default:   code = CMD_ALU_NOP;
        endcase
        return code;
    endfunction

    function automatic logic [2:0] frame_len(input cmd_type_e t);
        logic [2:0] len;
        case (t)
            CT_RF_WR:  len = FRAME_LEN_RF_WR;
            CT_RF_RD:  len = FRAME_LEN_RF_RD;
            CT_ALU_OP: len = FRAME_LEN_ALU_OP;
            default:   len = FRAME_LEN_ALU_NOP;
        endcase
        return len;
    endfunction

    function automatic logic [1:0] rsp_len(input cmd_type_e t);
        logic [1:0] len;
        case (t)
            CT_RF_WR:  len = RSP_LEN_RF_WR;
            CT_RF_RD:  len = RSP_LEN_RF_RD;
            CT_ALU_OP: len = RSP_LEN_ALU_OP;
            default:   len = RSP_LEN_ALU_NOP;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sys_cmd_host_timer.sv
`default_nettype none
// ============================================================================
// Module      : host_rsp_timer
// Description : Loadable down-counter guarding the gap between response
//               bytes. o_expire flags the decrement that lands on zero, so a
//               load of N aborts after N consecutive idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module host_rsp_timer #(
    parameter int WIDTH = 16,
    parameter int LOAD  = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_expire
);

    localparam logic [WIDTH-1:0] c_load = WIDTH'(LOAD);
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Reload has priority over decrement; the count parks at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_load;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    assign o_expire = i_dec && !i_load && (r_count == c_one);

endmodule
`default_nettype wire

// File: rtl/sys_cmd_host.sv
`default_nettype none
// ============================================================================
// Module      : sys_cmd_host
// Description : Host-side command initiator. Serializes one parallel command
//               into the UART register/ALU protocol byte stream and collects
//               the response bytes into one parallel response.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_cmd_host
    import sys_cmd_host_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int RF_ADDR     = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_type,
    input  logic [RF_ADDR-1:0]      cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_op_a,
    input  logic [DATA_WIDTH-1:0]   cmd_op_b,
    input  logic [3:0]              cmd_fun,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    output logic                    rsp_valid,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
    output logic                    rsp_timeout
);

    localparam int c_tmr_w = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    state_e                  r_state;
    cmd_type_e               r_type;
    logic [RF_ADDR-1:0]      r_addr;
    logic [DATA_WIDTH-1:0]   r_op_a;
    logic [DATA_WIDTH-1:0]   r_op_b;
    logic [3:0]              r_fun;
    logic [2:0]              r_idx;
    logic [1:0]              r_rx_cnt;
    logic                    r_cmd_ready;
    logic                    r_tx_valid;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_rsp_valid;
    logic [2*DATA_WIDTH-1:0] r_rsp_data;
    logic                    r_rsp_timeout;

    logic      w_accept;
    logic      w_tx_fire;
    logic      w_last_byte;
    logic      w_rx_last;
    logic [1:0] w_rsp_len;
    logic      w_tmr_load;
    logic      w_tmr_dec;
    logic      w_tmr_expire;

    // Byte idx of a frame; index 0 is always the command code
    function automatic logic [DATA_WIDTH-1:0] f_frame_byte(
        input cmd_type_e             t,
        input logic [RF_ADDR-1:0]    addr,
        input logic [DATA_WIDTH-1:0] op_a,
        input logic [DATA_WIDTH-1:0] op_b,
        input logic [3:0]            fun,
        input logic [2:0]            idx
    );
        logic [DATA_WIDTH-1:0] b;
        b = '0;
        if (idx == 3'd0) begin
            b = DATA_WIDTH'(cmd_code(t));
        end else begin
            case (t)
                CT_RF_WR:  b = (idx == 3'd1) ? DATA_WIDTH'(addr) : op_a;
                CT_RF_RD:  b = DATA_WIDTH'(addr);
                CT_ALU_OP: begin
                    case (idx)
                        3'd1:    b = op_a;
                        3'd2:    b = op_b;
                        default: b = DATA_WIDTH'(fun);
                    endcase
                end
                default:   b = DATA_WIDTH'(fun);
            endcase
        end
        return b;
    endfunction

    assign w_accept    = cmd_valid && r_cmd_ready && (r_state == ST_IDLE);
    assign w_tx_fire   = r_tx_valid && tx_ready;
    assign w_last_byte = (r_idx == (frame_len(r_type) - 3'd1));
    assign w_rsp_len   = rsp_len(r_type);
    assign w_rx_last   = ((r_rx_cnt + 2'd1) == w_rsp_len);

    // Timer reloads on entry to WAIT_RSP and on every received byte
    assign w_tmr_load = ((r_state == ST_SEND) && w_tx_fire && w_last_byte && (w_rsp_len != 2'd0))
                     || ((r_state == ST_WAIT_RSP) && rx_valid);
    assign w_tmr_dec  = (r_state == ST_WAIT_RSP) && !rx_valid;

    host_rsp_timer #(
        .WIDTH (c_tmr_w),
        .LOAD  (TIMEOUT_CYC)
    ) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .i_load   (w_tmr_load),
        .i_dec    (w_tmr_dec),
        .o_expire (w_tmr_expire)
    );

    // Command FSM with registered handshake, TX and response outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= ST_IDLE;
            r_type        <= CT_RF_WR;
            r_addr        <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_fun         <= '0;
            r_idx         <= '0;
            r_rx_cnt      <= '0;
            r_cmd_ready   <= 1'b1;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_type        <= cmd_type_e'(cmd_type);
                        r_addr        <= cmd_addr;
                        r_op_a        <= cmd_op_a;
                        r_op_b        <= cmd_op_b;
                        r_fun         <= cmd_fun;
                        r_idx         <= 3'd0;
                        r_rx_cnt      <= 2'd0;
                        r_rsp_data    <= '0;
                        r_rsp_timeout <= 1'b0;
                        r_cmd_ready   <= 1'b0;
                        r_tx_valid    <= 1'b1;
                        r_tx_data     <= f_frame_byte(cmd_type_e'(cmd_type), cmd_addr,
                                                      cmd_op_a, cmd_op_b, cmd_fun, 3'd0);
                        r_state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_tx_fire) begin
                        if (w_last_byte) begin
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= '0;
                            if (w_rsp_len == 2'd0) begin
                                r_rsp_valid <= 1'b1;
                                r_state     <= ST_DONE;
                            end else begin
                                r_state <= ST_WAIT_RSP;
                            end
                        end else begin
                            r_idx     <= r_idx + 3'd1;
                            r_tx_data <= f_frame_byte(r_type, r_addr, r_op_a, r_op_b,
                                                      r_fun, r_idx + 3'd1);
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    // A byte arriving on the expiring cycle takes precedence
                    if (rx_valid) begin
                        if (r_rx_cnt == 2'd0) begin
                            r_rsp_data[DATA_WIDTH-1:0] <= rx_data;
                        end else begin
                            r_rsp_data[2*DATA_WIDTH-1:DATA_WIDTH] <= rx_data;
                        end
                        r_rx_cnt <= r_rx_cnt + 2'd1;
                        if (w_rx_last) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end else if (w_tmr_expire) begin
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sys_cmd_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_cmd_host
// Description : Directed self-checking bench for sys_cmd_host. Inputs are
//               driven on the falling edge, outputs sampled on it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_cmd_host;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 16;

    logic          CLK;
    logic          RST;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_type;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_op_a;
    logic [DW-1:0] cmd_op_b;
    logic [3:0]    cmd_fun;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rsp_valid;
    logic [2*DW-1:0] rsp_data;
    logic          rsp_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] tx_got [8];
    int         tx_cnt;
    logic [7:0] stall_got [16];
    int         stall_pos [16];
    int         stall_cnt;
    int         lat;

    sys_cmd_host #(
        .DATA_WIDTH  (DW),
        .RF_ADDR     (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_type    (cmd_type),
        .cmd_addr    (cmd_addr),
        .cmd_op_a    (cmd_op_a),
        .cmd_op_b    (cmd_op_b),
        .cmd_fun     (cmd_fun),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Present one command for a single rising edge, then scramble the fields
    task automatic accept(input logic [1:0] t, input logic [3:0] a,
                          input logic [7:0] opa, input logic [7:0] opb,
                          input logic [3:0] f);
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_type = t; cmd_addr = a;
        cmd_op_a = opa; cmd_op_b = opb; cmd_fun = f;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0; cmd_type = ~t; cmd_addr = ~a;
        cmd_op_a = ~opa; cmd_op_b = ~opb; cmd_fun = ~f;
    endtask

    // Act as the UART TX sink; records transfers and stalled offers
    task automatic drive_tx(input int n, input bit toggle);
        int cyc;
        bit rdy;
        cyc = 0; tx_cnt = 0; stall_cnt = 0;
        while (tx_cnt < n && cyc < 40) begin
            @(negedge CLK);
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            tx_ready = rdy;
            if (tx_valid) begin
                if (rdy) begin
                    tx_got[tx_cnt] = tx_data;
                    tx_cnt++;
                end else if (stall_cnt < 16) begin
                    stall_got[stall_cnt] = tx_data;
                    stall_pos[stall_cnt] = tx_cnt;
                    stall_cnt++;
                end
            end
            cyc++;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge CLK);
        rx_valid = 1'b1; rx_data = b;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    // lat = number of falling edges until rsp_valid is seen (0 = never)
    task automatic wait_rsp(input int max_cyc);
        int k;
        lat = 0;
        for (k = 1; k <= max_cyc; k++) begin
            @(negedge CLK);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_addr = '0;
        cmd_op_a = '0; cmd_op_b = '0; cmd_fun = '0; tx_ready = 1'b1;
        rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(negedge CLK);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_data !== 16'h0000) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
        n_cmp++; if (rsp_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_timeout: got %b want 0", rsp_timeout); end
        RST = 1'b0;
        @(negedge CLK);
        n_cmp++; if (cmd_ready !== 1'b1 || tx_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: got ready=%b txv=%b want 1/0", cmd_ready, tx_valid); end
    endtask

    task automatic test_rf_rd();
        logic [7:0] exp [2];
        exp = '{8'hBB, 8'h02};
        accept(2'd1, 4'd2, 8'h00, 8'h00, 4'd0);
        drive_tx(2, 1'b0);
        n_cmp++; if (tx_cnt !== 2) begin n_bad++; $display("FAIL rd_tx_count: got %0d want 2", tx_cnt); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (tx_got[i] !== exp[i]) begin n_bad++; $display("FAIL rd_tx_byte%0d: got %h want %h", i, tx_got[i], exp[i]); end
        end
        send_rx(8'h81);
        wait_rsp(10);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rd_latency: got %0d want 1", lat); end
        n_cmp++; if (rsp_data !== 16'h0081) begin n_bad++; $display("FAIL rd_rsp_data: got %h want 0081", rsp_data); end
        n_cmp++; if (rsp_timeout !== 1'b0) begin n_bad++; $display("FAIL rd_rsp_timeout: got %b want 0", rsp_timeout); end
        @(negedge CLK);
        n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rd_after_rsp: got rspv=%b ready=%b want 0/1", rsp_valid, cmd_ready); end
        n_cmp++; if (rsp_data !== 16'h0081) begin n_bad++; $display("FAIL rd_rsp_hold: got %h want 0081", rsp_data); end
    endtask

    task automatic test_rf_wr();
        logic [7:0] exp [3];
        exp = '{8'hAA, 8'h03, 8'h5A};
        accept(2'd0, 4'd3, 8'h5A, 8'h00, 4'd0);
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL wr_ready_drop: got %b want 0", cmd_ready); end
        drive_tx(3, 1'b0);
        n_cmp++; if (tx_cnt !== 3) begin n_bad++; $display("FAIL wr_tx_count: got %0d want 3", tx_cnt); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (tx_got[i] !== exp[i]) begin n_bad++; $display("FAIL wr_tx_byte%0d: got %h want %h", i, tx_got[i], exp[i]); end
        end
        wait_rsp(10);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wr_latency: got %0d want 1", lat); end
        n_cmp++; if (rsp_data !== 16'h0000) begin n_bad++; $display("FAIL wr_rsp_data: got %h want 0000", rsp_data); end
        n_cmp++; if (rsp_timeout !== 1'b0) begin n_bad++; $display("FAIL wr_rsp_timeout: got %b want 0", rsp_timeout); end
        @(negedge CLK);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL wr_ready_return: got %b want 1", cmd_ready); end
    endtask

    task automatic test_alu_stall();
        logic [7:0] exp [4];
        exp = '{8'hCC, 8'h10, 8'h20, 8'h00};
        accept(2'd2, 4'd0, 8'h10, 8'h20, 4'd0);
        drive_tx(4, 1'b1);
        n_cmp++; if (tx_cnt !== 4) begin n_bad++; $display("FAIL alu_tx_count: got %0d want 4", tx_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (tx_got[i] !== exp[i]) begin n_bad++; $display("FAIL alu_tx_byte%0d: got %h want %h", i, tx_got[i], exp[i]); end
        end
        n_cmp++; if (stall_cnt !== 3) begin n_bad++; $display("FAIL alu_stall_count: got %0d want 3", stall_cnt); end
        for (int i = 0; i < stall_cnt; i++) begin
            n_cmp++; if (stall_got[i] !== exp[stall_pos[i]]) begin n_bad++; $display("FAIL alu_stall_hold%0d: got %h want %h", i, stall_got[i], exp[stall_pos[i]]); end
        end
        send_rx(8'h30);
        send_rx(8'h00);
        wait_rsp(10);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL alu_latency: got %0d want 1", lat); end
        n_cmp++; if (rsp_data !== 16'h0030) begin n_bad++; $display("FAIL alu_rsp_data: got %h want 0030", rsp_data); end
        n_cmp++; if (rsp_timeout !== 1'b0) begin n_bad++; $display("FAIL alu_rsp_timeout: got %b want 0", rsp_timeout); end
    endtask

    // One byte only: abort lands after 16 idle cycles, i.e. the 17th falling edge
    task automatic test_timeout();
        logic [7:0] exp [2];
        exp = '{8'hDD, 8'h02};
        accept(2'd3, 4'd0, 8'h00, 8'h00, 4'd2);
        drive_tx(2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (tx_got[i] !== exp[i]) begin n_bad++; $display("FAIL nop_tx_byte%0d: got %h want %h", i, tx_got[i], exp[i]); end
        end
        send_rx(8'h44);
        wait_rsp(40);
        n_cmp++; if (lat !== TO + 1) begin n_bad++; $display("FAIL nop_timeout_latency: got %0d want %0d", lat, TO + 1); end
        n_cmp++; if (rsp_timeout !== 1'b1) begin n_bad++; $display("FAIL nop_rsp_timeout: got %b want 1", rsp_timeout); end
        n_cmp++; if (rsp_data !== 16'h0044) begin n_bad++; $display("FAIL nop_rsp_data: got %h want 0044", rsp_data); end
        @(negedge CLK);
        n_cmp++; if (rsp_timeout !== 1'b1) begin n_bad++; $display("FAIL nop_timeout_hold: got %b want 1", rsp_timeout); end
    endtask

    task automatic test_stray();
        logic [7:0] exp [2];
        logic [7:0] exp2 [3];
        exp  = '{8'hBB, 8'h05};
        exp2 = '{8'hAA, 8'h01, 8'h11};
        @(negedge CLK);
        rx_valid = 1'b1; rx_data = 8'h99;
        @(negedge CLK);
        rx_valid = 1'b0;
        accept(2'd1, 4'd5, 8'h00, 8'h00, 4'd0);
        @(negedge CLK);
        tx_ready = 1'b0; rx_valid = 1'b1; rx_data = 8'h77;
        cmd_valid = 1'b1; cmd_type = 2'd0; cmd_addr = 4'hF; cmd_op_a = 8'hEE;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready: got %b want 0", cmd_ready); end
        @(negedge CLK);
        rx_valid = 1'b0;
        @(negedge CLK);
        cmd_valid = 1'b0;
        drive_tx(2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (tx_got[i] !== exp[i]) begin n_bad++; $display("FAIL stray_tx_byte%0d: got %h want %h", i, tx_got[i], exp[i]); end
        end
        send_rx(8'h66);
        wait_rsp(10);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL stray_latency: got %0d want 1", lat); end
        n_cmp++; if (rsp_data !== 16'h0066 || rsp_timeout !== 1'b0) begin n_bad++; $display("FAIL stray_rsp: got %h/%b want 0066/0", rsp_data, rsp_timeout); end
        accept(2'd0, 4'd1, 8'h11, 8'h00, 4'd0);
        drive_tx(3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (tx_got[i] !== exp2[i]) begin n_bad++; $display("FAIL next_tx_byte%0d: got %h want %h", i, tx_got[i], exp2[i]); end
        end
        wait_rsp(10);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL next_latency: got %0d want 1", lat); end
    endtask

    task automatic test_reset_mid();
        int seen;
        logic [7:0] exp [2];
        exp = '{8'hBB, 8'h07};
        accept(2'd2, 4'd0, 8'h12, 8'h34, 4'd5);
        @(negedge CLK);
        tx_ready = 1'b1;
        @(negedge CLK);
        tx_ready = 1'b0;
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h12) begin n_bad++; $display("FAIL mid_byte1: got %b/%h want 1/12", tx_valid, tx_data); end
        RST = 1'b1;
        #1;
        n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_bad++; $display("FAIL mid_rst_tx: got %b/%h want 0/00", tx_valid, tx_data); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 1", cmd_ready); end
        @(negedge CLK);
        RST = 1'b0; tx_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (rsp_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL mid_no_rsp: got %0d pulses want 0", seen); end
        accept(2'd1, 4'd7, 8'h00, 8'h00, 4'd0);
        drive_tx(2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (tx_got[i] !== exp[i]) begin n_bad++; $display("FAIL fresh_tx_byte%0d: got %h want %h", i, tx_got[i], exp[i]); end
        end
        send_rx(8'hA5);
        wait_rsp(10);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL fresh_latency: got %0d want 1", lat); end
        n_cmp++; if (rsp_data !== 16'h00A5 || rsp_timeout !== 1'b0) begin n_bad++; $display("FAIL fresh_rsp: got %h/%b want 00A5/0", rsp_data, rsp_timeout); end
    endtask

    initial begin
        test_reset();
        test_rf_rd();
        test_rf_wr();
        test_alu_stall();
        test_timeout();
        test_stray();
        test_reset_mid();
        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
